// File: rtl/msrh_pkg.sv
// msrh_pkg: shared rename/freelist sizing plus the freelist controller FSM encoding
package msrh_pkg;
  localparam int DISP_SIZE = 2;
  localparam int FLIST_SIZE = 32;
  localparam int FLIST_RECOVER_CYC = 2;
  typedef enum logic [1:0] {RUN, STALL, RECOVER} flist_ctrl_state_t;
endpackage

// File: rtl/msrh_flist_cnt.sv
// msrh_flist_cnt: one lane's saturating free-entry counter with flush reload and sticky overflow
module msrh_flist_cnt #(
  parameter int FLIST_SIZE = 32,
  parameter int CNT_W = $clog2(FLIST_SIZE + 1)
) (
  input  logic             i_clk,
  input  logic             i_reset_n,
  input  logic             i_pop,
  input  logic             i_push,
  input  logic             i_reload,
  input  logic             i_freeze,
  output logic [CNT_W-1:0] o_cnt,
  output logic [CNT_W-1:0] o_cnt_next,
  output logic             o_ovf
);
  localparam logic [CNT_W:0] FULL = (CNT_W + 1)'(FLIST_SIZE);
  logic [CNT_W:0] sum;
  logic sat;
  always_comb begin
    sum = {1'b0, o_cnt} - (CNT_W + 1)'(i_pop) + (CNT_W + 1)'(i_push);
    sat = sum > FULL;
    o_cnt_next = i_freeze ? o_cnt : sat ? FULL[CNT_W-1:0] : sum[CNT_W-1:0];
  end
  // While frozen nothing is outstanding, so any commit push is an over-free
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      o_cnt <= FULL[CNT_W-1:0];
      o_ovf <= 1'b0;
    end else begin
      o_cnt <= i_reload ? FULL[CNT_W-1:0] : o_cnt_next;
      o_ovf <= o_ovf | (i_freeze ? i_push : sat);
    end
endmodule

// File: rtl/msrh_rename_flist_ctrl.sv
// msrh_rename_flist_ctrl: per-lane freelist count, dispatch-ready and flush recovery FSM
// Optional MSRH_RENAME_PERF_CNT_EN adds saturating stall/recover cycle counters.
module msrh_rename_flist_ctrl #(
  parameter int DISP_SIZE = msrh_pkg::DISP_SIZE,
  parameter int FLIST_SIZE = msrh_pkg::FLIST_SIZE,
  parameter int RECOVER_CYC = msrh_pkg::FLIST_RECOVER_CYC,
  localparam int CNT_W = $clog2(FLIST_SIZE + 1)
) (
  input  logic                       i_clk,
  input  logic                       i_reset_n,
  input  logic                       i_disp_valid,
  input  logic [DISP_SIZE-1:0]       i_disp_rd_valid,
  output logic                       o_disp_ready,
  output logic [DISP_SIZE-1:0]       o_flist_pop,
  input  logic                       i_cmt_valid,
  input  logic [DISP_SIZE-1:0]       i_cmt_rd_valid,
  output logic [DISP_SIZE-1:0]       o_flist_push,
  input  logic                       i_flush,
  output logic                       o_flist_restore,
  output logic                       o_recovering,
  output logic [DISP_SIZE*CNT_W-1:0] o_free_cnt,
  output logic                       o_err_overflow
`ifdef MSRH_RENAME_PERF_CNT_EN
  ,
  output logic [31:0]                o_perf_stall_cyc,
  output logic [31:0]                o_perf_recover_cyc
`endif
);
  import msrh_pkg::*;
  localparam int RCW = $clog2(RECOVER_CYC + 1);
  flist_ctrl_state_t state, state_next;
  logic [RCW-1:0] rcnt;
  logic [DISP_SIZE-1:0] zero_next, ovf;
  logic [DISP_SIZE*CNT_W-1:0] cnt_next;
  assign o_flist_pop = {DISP_SIZE{i_disp_valid & o_disp_ready}} & i_disp_rd_valid;
  assign o_flist_push = {DISP_SIZE{i_cmt_valid}} & i_cmt_rd_valid;
  assign o_recovering = state == RECOVER;
  assign o_err_overflow = |ovf;
  for (genvar d = 0; d < DISP_SIZE; d++) begin : g_lane
    msrh_flist_cnt #(.FLIST_SIZE(FLIST_SIZE), .CNT_W(CNT_W)) u_cnt (
      .i_clk(i_clk),
      .i_reset_n(i_reset_n),
      .i_pop(o_flist_pop[d]),
      .i_push(o_flist_push[d]),
      .i_reload(i_flush),
      .i_freeze(o_recovering),
      .o_cnt(o_free_cnt[d*CNT_W +: CNT_W]),
      .o_cnt_next(cnt_next[d*CNT_W +: CNT_W]),
      .o_ovf(ovf[d])
    );
    assign zero_next[d] = cnt_next[d*CNT_W +: CNT_W] == '0;
  end
  always_comb
    state_next = i_flush ? RECOVER :
                 (state == RECOVER && rcnt != '0) ? RECOVER :
                 |zero_next ? STALL : RUN;
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      state <= RUN;
      rcnt <= '0;
      o_disp_ready <= 1'b1;
      o_flist_restore <= 1'b0;
    end else begin
      state <= state_next;
      rcnt <= i_flush ? RCW'(RECOVER_CYC - 1) : rcnt != '0 ? rcnt - 1'b1 : rcnt;
      o_disp_ready <= state_next == RUN;
      o_flist_restore <= i_flush;
    end
`ifdef MSRH_RENAME_PERF_CNT_EN
  always_ff @(posedge i_clk)
    if (!i_reset_n) begin
      o_perf_stall_cyc <= '0;
      o_perf_recover_cyc <= '0;
    end else begin
      if (i_disp_valid && !o_disp_ready && !o_recovering && !(&o_perf_stall_cyc))
        o_perf_stall_cyc <= o_perf_stall_cyc + 1'b1;
      if (o_recovering && !(&o_perf_recover_cyc))
        o_perf_recover_cyc <= o_perf_recover_cyc + 1'b1;
    end
`endif
endmodule

// File: tb/tb_msrh_rename_flist_ctrl.sv
// tb_msrh_rename_flist_ctrl: directed stimulus against a per-cycle count/recovery model
module tb_msrh_rename_flist_ctrl;
  localparam int D = 2;
  localparam int FL = 32;
  localparam int RCY = 2;
  localparam int CW = $clog2(FL + 1);
  logic i_clk = 1'b0, i_reset_n = 1'b0;
  logic i_disp_valid = 1'b0, i_cmt_valid = 1'b0, i_flush = 1'b0;
  logic [D-1:0] i_disp_rd_valid = '0, i_cmt_rd_valid = '0;
  logic o_disp_ready, o_flist_restore, o_recovering, o_err_overflow;
  logic [D-1:0] o_flist_pop, o_flist_push;
  logic [D*CW-1:0] o_free_cnt;
`ifdef MSRH_RENAME_PERF_CNT_EN
  logic [31:0] o_perf_stall_cyc, o_perf_recover_cyc;
`endif
  int checks = 0, errors = 0;
  int m_cnt [D];
  int m_rec = 0;
  bit m_ovf = 0, m_ready = 1, m_restore = 0, started = 0;

  msrh_rename_flist_ctrl dut (
    .i_clk(i_clk), .i_reset_n(i_reset_n),
    .i_disp_valid(i_disp_valid), .i_disp_rd_valid(i_disp_rd_valid),
    .o_disp_ready(o_disp_ready), .o_flist_pop(o_flist_pop),
    .i_cmt_valid(i_cmt_valid), .i_cmt_rd_valid(i_cmt_rd_valid),
    .o_flist_push(o_flist_push), .i_flush(i_flush),
    .o_flist_restore(o_flist_restore), .o_recovering(o_recovering),
    .o_free_cnt(o_free_cnt), .o_err_overflow(o_err_overflow)
`ifdef MSRH_RENAME_PERF_CNT_EN
    , .o_perf_stall_cyc(o_perf_stall_cyc), .o_perf_recover_cyc(o_perf_recover_cyc)
`endif
  );

  always #5 i_clk = ~i_clk;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic int lane_cnt(input int d);
    return int'(o_free_cnt[d*CW +: CW]);
  endfunction

  // Model: counts as integers, recovery as a remaining-cycle budget
  always @(posedge i_clk) begin
    started = 1;
    if (!i_reset_n) begin
      foreach (m_cnt[d]) m_cnt[d] = FL;
      m_ovf = 0;
      m_rec = 0;
      m_ready = 1;
      m_restore = 0;
    end else begin
      for (int d = 0; d < D; d++) begin
        int pop, push, n;
        pop = (i_disp_valid && m_ready && i_disp_rd_valid[d]) ? 1 : 0;
        push = (i_cmt_valid && i_cmt_rd_valid[d]) ? 1 : 0;
        if (m_rec > 0) begin
          if (push == 1) m_ovf = 1;
        end else begin
          n = m_cnt[d] - pop + push;
          if (n > FL) begin
            m_ovf = 1;
            n = FL;
          end
          m_cnt[d] = n;
        end
        if (i_flush) m_cnt[d] = FL;
      end
      m_restore = i_flush;
      m_rec = i_flush ? RCY : (m_rec > 0 ? m_rec - 1 : 0);
      m_ready = m_rec == 0;
      foreach (m_cnt[d]) if (m_cnt[d] == 0) m_ready = 0;
    end
  end

  always @(negedge i_clk)
    if (started) begin
      chk("ready", int'(o_disp_ready), int'(m_ready));
      chk("restore", int'(o_flist_restore), int'(m_restore));
      chk("recovering", int'(o_recovering), (m_rec > 0) ? 1 : 0);
      chk("overflow", int'(o_err_overflow), int'(m_ovf));
      for (int d = 0; d < D; d++) begin
        chk($sformatf("cnt%0d", d), lane_cnt(d), m_cnt[d]);
        chk($sformatf("pop%0d", d), int'(o_flist_pop[d]),
            int'(i_disp_valid && m_ready && i_disp_rd_valid[d]));
        chk($sformatf("push%0d", d), int'(o_flist_push[d]), int'(i_cmt_valid && i_cmt_rd_valid[d]));
        chk($sformatf("pop_on_empty%0d", d), int'(o_flist_pop[d] && m_cnt[d] == 0), 0);
      end
    end

  task automatic drive(input bit v, input logic [D-1:0] rd, input bit cv, input logic [D-1:0] crd,
                       input bit fl);
    i_disp_valid = v;
    i_disp_rd_valid = rd;
    i_cmt_valid = cv;
    i_cmt_rd_valid = crd;
    i_flush = fl;
    @(posedge i_clk);
    #1;
  endtask

  initial begin
    repeat (2) @(posedge i_clk);
    #1;
    i_reset_n = 1'b1;
    chk("rst_cnt0", lane_cnt(0), 32);
    chk("rst_cnt1", lane_cnt(1), 32);
    chk("rst_ready", int'(o_disp_ready), 1);
    chk("rst_ovf", int'(o_err_overflow), 0);
    repeat (32) drive(1, 2'b01, 0, 2'b00, 0);
    chk("drain_cnt0", lane_cnt(0), 0);
    chk("drain_cnt1", lane_cnt(1), 32);
    chk("drain_ready", int'(o_disp_ready), 0);
    drive(1, 2'b01, 0, 2'b00, 0);
    chk("stall_hold_cnt0", lane_cnt(0), 0);
    drive(0, 2'b00, 1, 2'b01, 0);
    chk("refill_cnt0", lane_cnt(0), 1);
    chk("refill_ready", int'(o_disp_ready), 1);
    drive(1, 2'b01, 0, 2'b00, 0);
    chk("resume_cnt0", lane_cnt(0), 0);
    repeat (5) drive(0, 2'b00, 1, 2'b01, 0);
    chk("five_cnt0", lane_cnt(0), 5);
    i_disp_valid = 1'b1;
    i_disp_rd_valid = 2'b01;
    i_cmt_valid = 1'b1;
    i_cmt_rd_valid = 2'b01;
    #1;
    chk("both_pop0", int'(o_flist_pop[0]), 1);
    chk("both_push0", int'(o_flist_push[0]), 1);
    drive(1, 2'b01, 1, 2'b01, 0);
    chk("both_cnt0", lane_cnt(0), 5);
    repeat (5) drive(1, 2'b10, 1, 2'b01, 0);
    repeat (7) drive(1, 2'b10, 0, 2'b00, 0);
    chk("pre_flush_cnt0", lane_cnt(0), 10);
    chk("pre_flush_cnt1", lane_cnt(1), 20);
    drive(0, 2'b00, 0, 2'b00, 1);
    chk("flush_restore", int'(o_flist_restore), 1);
    chk("flush_ready", int'(o_disp_ready), 0);
    chk("flush_cnt0", lane_cnt(0), 32);
    chk("flush_cnt1", lane_cnt(1), 32);
    drive(0, 2'b00, 0, 2'b00, 0);
    chk("rec2_restore", int'(o_flist_restore), 0);
    chk("rec2_ready", int'(o_disp_ready), 0);
    drive(0, 2'b00, 0, 2'b00, 0);
    chk("rec_done_ready", int'(o_disp_ready), 1);
    chk("rec_done_recovering", int'(o_recovering), 0);
    drive(0, 2'b00, 0, 2'b00, 1);
    drive(0, 2'b00, 0, 2'b00, 0);
    drive(0, 2'b00, 0, 2'b00, 1);
    chk("reflush_restore", int'(o_flist_restore), 1);
    chk("reflush_ready", int'(o_disp_ready), 0);
    drive(0, 2'b00, 0, 2'b00, 0);
    chk("reflush_hold_ready", int'(o_disp_ready), 0);
    drive(0, 2'b00, 0, 2'b00, 0);
    chk("reflush_done_ready", int'(o_disp_ready), 1);
    drive(0, 2'b00, 1, 2'b10, 0);
    chk("ovf_set", int'(o_err_overflow), 1);
    chk("ovf_cnt1", lane_cnt(1), 32);
    repeat (3) drive(0, 2'b00, 0, 2'b00, 0);
    chk("ovf_sticky", int'(o_err_overflow), 1);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
